// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the ALU/load-unit writeback requesters, the register-file write
// port, the forwarding lookups and the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  stall_i;

    logic                  alu_valid_i;
    logic                  alu_ready_o;
    logic [ADDR_WIDTH-1:0] alu_addr_i;
    logic [DATA_WIDTH-1:0] alu_data_i;

    logic                  mem_valid_i;
    logic                  mem_ready_o;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [DATA_WIDTH-1:0] mem_data_i;

    logic                  wr_en_o;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [DATA_WIDTH-1:0] wr_data_o;

    logic [ADDR_WIDTH-1:0] fwd_addr1_i;
    logic [ADDR_WIDTH-1:0] fwd_addr2_i;
    logic                  fwd_hit1_o;
    logic                  fwd_hit2_o;
    logic [DATA_WIDTH-1:0] fwd_data1_o;
    logic [DATA_WIDTH-1:0] fwd_data2_o;

    logic [15:0]           conflict_cnt_o;

    modport slave (
        input  stall_i,
        input  alu_valid_i, alu_addr_i, alu_data_i,
        output alu_ready_o,
        input  mem_valid_i, mem_addr_i, mem_data_i,
        output mem_ready_o,
        output wr_en_o, wr_addr_o, wr_data_o,
        input  fwd_addr1_i, fwd_addr2_i,
        output fwd_hit1_o, fwd_hit2_o, fwd_data1_o, fwd_data2_o,
        output conflict_cnt_o
    );

    modport master (
        output stall_i,
        output alu_valid_i, alu_addr_i, alu_data_i,
        input  alu_ready_o,
        output mem_valid_i, mem_addr_i, mem_data_i,
        input  mem_ready_o,
        input  wr_en_o, wr_addr_o, wr_data_o,
        output fwd_addr1_i, fwd_addr2_i,
        input  fwd_hit1_o, fwd_hit2_o, fwd_data1_o, fwd_data2_o,
        input  conflict_cnt_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter with round-robin on contention, a registered
// write port, same-cycle forwarding of the in-flight write and a conflict counter.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    regfile_wb_arbiter_if.slave  bus
);

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

    prio_e                 prio_q;
    prio_e                 prio_d;
    logic                  alu_grant;
    logic                  mem_grant;
    logic                  contended;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [15:0]           conflict_cnt_q;

    // Priority only flips on a contended grant so a lone requester never steals a turn.
    always_comb begin
        prio_d    = prio_q;
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        contended = 1'b0;
        sel_write = 1'b0;
        sel_addr  = bus.alu_addr_i;
        sel_data  = bus.alu_data_i;
        if (!rst_i && !bus.stall_i) begin
            contended = bus.alu_valid_i && bus.mem_valid_i;
            if (contended) begin
                if (prio_q == PRIO_ALU) begin
                    alu_grant = 1'b1;
                    prio_d    = PRIO_MEM;
                end else begin
                    mem_grant = 1'b1;
                    prio_d    = PRIO_ALU;
                end
            end else begin
                alu_grant = bus.alu_valid_i;
                mem_grant = bus.mem_valid_i;
            end
        end
        if (mem_grant) begin
            sel_addr = bus.mem_addr_i;
            sel_data = bus.mem_data_i;
        end
        sel_write = (alu_grant || mem_grant) && (sel_addr != '0);
    end

    // Transfers to register 0 are consumed but leave the write port untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q         <= PRIO_ALU;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            prio_q  <= prio_d;
            wr_en_q <= sel_write;
            if (sel_write) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
            if (contended && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign bus.alu_ready_o    = alu_grant;
    assign bus.mem_ready_o    = mem_grant;
    assign bus.wr_en_o        = wr_en_q;
    assign bus.wr_addr_o      = wr_addr_q;
    assign bus.wr_data_o      = wr_data_q;
    assign bus.conflict_cnt_o = conflict_cnt_q;

    assign bus.fwd_hit1_o  = wr_en_q && (wr_addr_q == bus.fwd_addr1_i) && (bus.fwd_addr1_i != '0);
    assign bus.fwd_hit2_o  = wr_en_q && (wr_addr_q == bus.fwd_addr2_i) && (bus.fwd_addr2_i != '0);
    assign bus.fwd_data1_o = wr_data_q;
    assign bus.fwd_data2_o = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter, checked every cycle against
// a behavioural model of grants, write-port contents and the conflict counter.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: whose turn it is on contention, what the write port holds.
    int          m_turn;
    logic        m_en;
    logic        m_known;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int          m_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_turn  = 0;
        m_en    = 1'b0;
        m_known = 1'b1;
        m_addr  = '0;
        m_data  = '0;
        m_cnt   = 0;
    endtask

    // Called just after a falling edge; returns -1 (no grant), 0 (ALU) or 1 (MEM).
    task automatic applyStimulus(input logic rst, input logic stall,
                                 input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                                 input logic [AW-1:0] f1, input logic [AW-1:0] f2,
                                 output int grant);
        int g;
        rst_i           = rst;
        bus.stall_i     = stall;
        bus.alu_valid_i = av;
        bus.alu_addr_i  = aa;
        bus.alu_data_i  = ad;
        bus.mem_valid_i = mv;
        bus.mem_addr_i  = ma;
        bus.mem_data_i  = md;
        bus.fwd_addr1_i = f1;
        bus.fwd_addr2_i = f2;
        #1;
        if (rst || stall)  g = -1;
        else if (av && mv) g = m_turn;
        else if (av)       g = 0;
        else if (mv)       g = 1;
        else               g = -1;

        checkOutput("alu_ready", {31'd0, bus.alu_ready_o}, {31'd0, g == 0});
        checkOutput("mem_ready", {31'd0, bus.mem_ready_o}, {31'd0, g == 1});
        checkOutput("wr_en", {31'd0, bus.wr_en_o}, {31'd0, m_en});
        checkOutput("fwd_hit1", {31'd0, bus.fwd_hit1_o}, {31'd0, m_en && (m_addr == f1) && (f1 != 0)});
        checkOutput("fwd_hit2", {31'd0, bus.fwd_hit2_o}, {31'd0, m_en && (m_addr == f2) && (f2 != 0)});
        checkOutput("conflict_cnt", {16'd0, bus.conflict_cnt_o}, m_cnt);
        if (m_known) begin
            checkOutput("wr_addr", {27'd0, bus.wr_addr_o}, {27'd0, m_addr});
            checkOutput("wr_data", bus.wr_data_o, m_data);
            checkOutput("fwd_data1", bus.fwd_data1_o, m_data);
            checkOutput("fwd_data2", bus.fwd_data2_o, m_data);
        end

        @(posedge clk_i);
        if (rst) begin
            modelReset();
        end else begin
            m_en = 1'b0;
            if (g >= 0) begin
                logic [AW-1:0] ga;
                ga = (g == 0) ? aa : ma;
                if (ga != 0) begin
                    m_en    = 1'b1;
                    m_addr  = ga;
                    m_data  = (g == 0) ? ad : md;
                    m_known = 1'b1;
                end else begin
                    m_known = (bus.wr_en_o === 1'b1) ? m_known : m_known;
                    m_known = 1'b0;
                end
            end
            if (av && mv && !stall) begin
                m_turn = 1 - g;
                m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end
        end
        @(negedge clk_i);
        grant = g;
    endtask

    initial begin
        int g;
        logic          a_pend, m_pend;
        logic [AW-1:0] a_addr, m_addr_r;
        logic [DW-1:0] a_data, m_data_r;

        rst_i = 1'b1;
        bus.stall_i = 1'b0;
        bus.alu_valid_i = 1'b0; bus.alu_addr_i = '0; bus.alu_data_i = '0;
        bus.mem_valid_i = 1'b0; bus.mem_addr_i = '0; bus.mem_data_i = '0;
        bus.fwd_addr1_i = '0;   bus.fwd_addr2_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        modelReset();

        // Reset cycle with both requesters asking: nothing may be accepted.
        applyStimulus(1, 0, 1, 5'd4, 32'h1111, 1, 5'd6, 32'h2222, 5'd4, 5'd6, g);
        checkOutput("rst_grant", g, -1);
        applyStimulus(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd4, 5'd6, g);
        checkOutput("post_rst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);

        applyStimulus(0, 0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0, 5'd0, 5'd0, g);
        checkOutput("alu_only_grant", g, 0);
        checkOutput("alu_only_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
        checkOutput("alu_only_addr", {27'd0, bus.wr_addr_o}, 32'd3);
        checkOutput("alu_only_data", bus.wr_data_o, 32'hDEADBEEF);

        applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0, g);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 5'd1, 32'hA0 + i, 1, 5'd2, 32'hB0 + i, 5'd1, 5'd2, g);
            checkOutput("rr_grant", g, i % 2);
        end
        checkOutput("rr_conflicts", {16'd0, bus.conflict_cnt_o}, 32'd4);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 1, 5'd1, 32'hC0, 1, 5'd2, 32'hD0, 5'd1, 5'd2, g);
            checkOutput("stall_grant", g, -1);
            checkOutput("stall_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
        end
        checkOutput("stall_conflicts", {16'd0, bus.conflict_cnt_o}, 32'd4);
        applyStimulus(0, 0, 1, 5'd1, 32'hC0, 1, 5'd2, 32'hD0, 5'd1, 5'd2, g);
        checkOutput("unstall_grant", g, 0);

        applyStimulus(0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h55, 5'd0, 5'd0, g);
        checkOutput("mem_zero_grant", g, 1);
        checkOutput("mem_zero_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
        applyStimulus(0, 0, 1, 5'd0, 32'h66, 0, 5'd0, 32'h0, 5'd0, 5'd0, g);
        checkOutput("alu_zero_grant", g, 0);
        checkOutput("alu_zero_wr_en", {31'd0, bus.wr_en_o}, 32'd0);

        applyStimulus(0, 0, 1, 5'd7, 32'h12345678, 0, 5'd0, 32'h0, 5'd0, 5'd0, g);
        applyStimulus(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, 5'd0, g);

        applyStimulus(0, 0, 1, 5'd9, 32'h9, 1, 5'd10, 32'hA, 5'd0, 5'd0, g);
        applyStimulus(1, 0, 1, 5'd9, 32'h9, 1, 5'd10, 32'hA, 5'd0, 5'd0, g);
        checkOutput("midrst_grant", g, -1);
        checkOutput("midrst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
        applyStimulus(0, 0, 1, 5'd9, 32'h9, 1, 5'd10, 32'hA, 5'd9, 5'd10, g);
        checkOutput("midrst_first_grant", g, 0);
        checkOutput("midrst_conflicts", {16'd0, bus.conflict_cnt_o}, 32'd1);

        // Requesters hold their transfer stable until granted, then maybe issue another.
        a_pend = 1'b0; m_pend = 1'b0;
        a_addr = '0; a_data = '0; m_addr_r = '0; m_data_r = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic rst_r, stall_r;
            logic [AW-1:0] f1, f2;
            if (!a_pend && ($urandom_range(0, 3) != 0)) begin
                a_pend = 1'b1;
                a_addr = AW'($urandom_range(0, 7));
                a_data = $urandom;
            end
            if (!m_pend && ($urandom_range(0, 3) != 0)) begin
                m_pend   = 1'b1;
                m_addr_r = AW'($urandom_range(0, 7));
                m_data_r = $urandom;
            end
            rst_r   = ($urandom_range(0, 59) == 0);
            stall_r = ($urandom_range(0, 4) == 0);
            f1 = ($urandom_range(0, 1) == 0) ? m_addr : AW'($urandom_range(0, 7));
            f2 = AW'($urandom_range(0, 7));
            applyStimulus(rst_r, stall_r, a_pend, a_addr, a_data, m_pend, m_addr_r, m_data_r, f1, f2, g);
            if (g == 0) a_pend = 1'b0;
            if (g == 1) m_pend = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
